// File: rtl/fluid_board_soc_irq_ctrl_pkg.sv
// Shared constants for the fluid board interrupt aggregator: register map, widths, reset values.
// Latency: n/a (declarations only). Backpressure: n/a.
package fluid_irq_pkg;

  localparam int IRQ_MAX_SRC = 16;
  localparam int IRQ_ADDR_W  = 3;
  localparam int IRQ_DATA_W  = 16;

  localparam logic [IRQ_ADDR_W-1:0] IRQ_ADDR_PENDING  = 3'd0;
  localparam logic [IRQ_ADDR_W-1:0] IRQ_ADDR_MASK     = 3'd1;
  localparam logic [IRQ_ADDR_W-1:0] IRQ_ADDR_STATUS   = 3'd2;
  localparam logic [IRQ_ADDR_W-1:0] IRQ_ADDR_EDGE_SEL = 3'd3;
  localparam logic [IRQ_ADDR_W-1:0] IRQ_ADDR_OVR_CNT  = 3'd4;
  localparam logic [IRQ_ADDR_W-1:0] IRQ_ADDR_OVR_SEL  = 3'd5;

  // Every source comes out of reset in rising-edge capture mode.
  localparam logic [IRQ_MAX_SRC-1:0] IRQ_EDGE_SEL_RST = 16'hFFFF;

  typedef struct packed {
    logic [IRQ_ADDR_W-1:0] addr;
    logic [IRQ_DATA_W-1:0] wdat;
    logic                  wr;
  } irq_bus_req_t;

endpackage

// File: rtl/fluid_board_soc_irq_ctrl_if.sv
// Avalon-MM slave bus bundle for the interrupt aggregator.
// Latency: readdata is registered, one cycle. Backpressure: none (no waitrequest).
interface fluid_board_soc_irq_ctrl_if;
  import fluid_irq_pkg::*;

  logic [IRQ_ADDR_W-1:0] address;
  logic                  chipselect;
  logic                  write_n;
  logic [IRQ_DATA_W-1:0] writedata;
  logic [IRQ_DATA_W-1:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );

endinterface

// File: rtl/fluid_board_soc_irq_ctrl_ovr_cnt.sv
// Saturating per-source overrun counter, built only with FLUID_IRQ_OVERRUN_CNT_EN.
// Latency: count visible one cycle after inc/clr. Backpressure: none; clr beats inc.
module fluid_irq_ovr_cnt #(
  parameter int OVR_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             clr,
  output logic [OVR_W-1:0] cnt
);

  logic [OVR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {OVR_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/fluid_board_soc_irq_ctrl.sv
// Interrupt aggregator: pending/mask/edge-select with W1C ack; overrun counters under FLUID_IRQ_OVERRUN_CNT_EN.
// Latency: pending 1 cycle after event, irq 1 cycle after pending, readdata 1 cycle. Backpressure: none.
module fluid_board_soc_irq_ctrl
  import fluid_irq_pkg::*;
#(
  parameter int NUM_SRC = 8,
  parameter int OVR_W   = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  fluid_board_soc_irq_ctrl_if.slave  avs,
  input  logic [NUM_SRC-1:0]         irq_in,
  output logic                       irq
);

  irq_bus_req_t req;
  logic         wr_pend, wr_mask, wr_edge;
  logic         unused_wdat;

  logic [NUM_SRC-1:0]    wdat_src;
  logic [NUM_SRC-1:0]    evt, clr;
  logic [NUM_SRC-1:0]    pend_q, pend_d;
  logic [NUM_SRC-1:0]    mask_q, mask_d;
  logic [NUM_SRC-1:0]    edge_sel_q, edge_sel_d;
  logic [NUM_SRC-1:0]    irq_prev_q;
  logic [IRQ_DATA_W-1:0] rdata_q, rdata_d;
  logic                  irq_q, irq_d;

  always_comb begin
    req.addr = avs.address;
    req.wdat = avs.writedata;
    req.wr   = avs.chipselect & ~avs.write_n;
  end

  assign wr_pend     = req.wr && (req.addr == IRQ_ADDR_PENDING);
  assign wr_mask     = req.wr && (req.addr == IRQ_ADDR_MASK);
  assign wr_edge     = req.wr && (req.addr == IRQ_ADDR_EDGE_SEL);
  assign wdat_src    = req.wdat[NUM_SRC-1:0];
  assign unused_wdat = ^req.wdat;

  // Edge mode needs a fresh rise; level mode re-asserts every cycle the line is high.
  always_comb begin
    evt        = irq_in & (~edge_sel_q | ~irq_prev_q);
    clr        = wr_pend ? wdat_src : '0;
    pend_d     = evt | (pend_q & ~clr);
    mask_d     = wr_mask ? wdat_src : mask_q;
    edge_sel_d = wr_edge ? wdat_src : edge_sel_q;
    irq_d      = |(pend_q & mask_q);
  end

`ifdef FLUID_IRQ_OVERRUN_CNT_EN
  logic               wr_ovr_cnt, wr_ovr_sel;
  logic [3:0]         ovr_sel_q, ovr_sel_d;
  logic [NUM_SRC-1:0] ovr_inc, ovr_clr;
  logic [OVR_W-1:0]   ovr_cnt [NUM_SRC];
  logic [OVR_W-1:0]   ovr_rd;

  assign wr_ovr_cnt = req.wr && (req.addr == IRQ_ADDR_OVR_CNT);
  assign wr_ovr_sel = req.wr && (req.addr == IRQ_ADDR_OVR_SEL);

  // An overrun is a new edge landing on a still-pending, unacknowledged bit.
  always_comb begin
    ovr_inc   = edge_sel_q & evt & pend_q & ~clr;
    ovr_sel_d = wr_ovr_sel ? req.wdat[3:0] : ovr_sel_q;
    ovr_clr   = '0;
    ovr_rd    = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (ovr_sel_q == 4'(i)) begin
        ovr_clr[i] = wr_ovr_cnt;
        ovr_rd     = ovr_cnt[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_ovr
    fluid_irq_ovr_cnt #(
      .OVR_W (OVR_W)
    ) u_ovr_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .inc     (ovr_inc[g]),
      .clr     (ovr_clr[g]),
      .cnt     (ovr_cnt[g])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovr_sel_q <= '0;
    end else begin
      ovr_sel_q <= ovr_sel_d;
    end
  end
`endif

  always_comb begin
    rdata_d = '0;
    case (req.addr)
      IRQ_ADDR_PENDING:  rdata_d[NUM_SRC-1:0] = pend_q;
      IRQ_ADDR_MASK:     rdata_d[NUM_SRC-1:0] = mask_q;
      IRQ_ADDR_STATUS:   rdata_d[NUM_SRC-1:0] = pend_q & mask_q;
      IRQ_ADDR_EDGE_SEL: rdata_d[NUM_SRC-1:0] = edge_sel_q;
`ifdef FLUID_IRQ_OVERRUN_CNT_EN
      IRQ_ADDR_OVR_CNT:  rdata_d[OVR_W-1:0]   = ovr_rd;
      IRQ_ADDR_OVR_SEL:  rdata_d[3:0]         = ovr_sel_q;
`endif
      default:           rdata_d              = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_q     <= '0;
      mask_q     <= '0;
      edge_sel_q <= IRQ_EDGE_SEL_RST[NUM_SRC-1:0];
      irq_prev_q <= '0;
      rdata_q    <= '0;
      irq_q      <= 1'b0;
    end else begin
      pend_q     <= pend_d;
      mask_q     <= mask_d;
      edge_sel_q <= edge_sel_d;
      irq_prev_q <= irq_in;
      rdata_q    <= rdata_d;
      irq_q      <= irq_d;
    end
  end

  assign avs.readdata = rdata_q;
  assign irq          = irq_q;

endmodule
